// File: rtl/match_pkg.sv
// -----------------------------------------------------------------------------
// match_pkg
// Shared types and constants for the baccarat match controller.
//   state_t  : controller state encoding
//   winner_t : match_winner output codes
//   TALLY_W  : width of every tally and of hands_played
//   sat_inc  : saturating increment used for all tallies
// -----------------------------------------------------------------------------
package match_pkg;

  localparam int TALLY_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HRST  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE   = 2'b00,
    WIN_PLAYER = 2'b01,
    WIN_DEALER = 2'b10,
    WIN_DRAW   = 2'b11
  } winner_t;

  // Tallies stick at all-ones instead of wrapping back to zero.
  function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] value);
    logic [TALLY_W-1:0] result;
    if (value == {TALLY_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + TALLY_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/match_controller_if.sv
// -----------------------------------------------------------------------------
// match_controller_if
// Bundles the match controller's game-side and display-side signals.
//   start            : start/restart request from the top level key
//   player_win_light : player win light from the game state machine
//   dealer_win_light : dealer win light from the game state machine
//   hand_resetb      : active-low synchronous reset back to the game
//   player_tally     : player hands won
//   dealer_tally     : dealer hands won
//   tie_tally        : tied hands
//   hands_played     : hands completed in this match
//   match_over       : high while the match is finished
//   match_winner     : 00 none, 01 player, 10 dealer, 11 draw
//   timeout_err      : watchdog flag, present only with MATCH_TIMEOUT_EN
// Modports:
//   master : top level / game side (drives start and the lights)
//   slave  : the match controller
// Optional feature macro: MATCH_TIMEOUT_EN
// -----------------------------------------------------------------------------
interface match_controller_if;

  logic                          start;
  logic                          player_win_light;
  logic                          dealer_win_light;
  logic                          hand_resetb;
  logic [match_pkg::TALLY_W-1:0] player_tally;
  logic [match_pkg::TALLY_W-1:0] dealer_tally;
  logic [match_pkg::TALLY_W-1:0] tie_tally;
  logic [match_pkg::TALLY_W-1:0] hands_played;
  logic                          match_over;
  logic [1:0]                    match_winner;
`ifdef MATCH_TIMEOUT_EN
  logic                          timeout_err;

  modport master (
    output start, player_win_light, dealer_win_light,
    input  hand_resetb, player_tally, dealer_tally, tie_tally,
    input  hands_played, match_over, match_winner, timeout_err
  );

  modport slave (
    input  start, player_win_light, dealer_win_light,
    output hand_resetb, player_tally, dealer_tally, tie_tally,
    output hands_played, match_over, match_winner, timeout_err
  );
`else
  modport master (
    output start, player_win_light, dealer_win_light,
    input  hand_resetb, player_tally, dealer_tally, tie_tally,
    input  hands_played, match_over, match_winner
  );

  modport slave (
    input  start, player_win_light, dealer_win_light,
    output hand_resetb, player_tally, dealer_tally, tie_tally,
    output hands_played, match_over, match_winner
  );
`endif

endinterface

// File: rtl/match_controller_cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
// Loadable down-counter with a done flag.
//   slow_clock : clock
//   resetb     : asynchronous active-high reset (count returns to 0)
//   load       : load load_value this cycle (wins over enable)
//   load_value : starting count
//   enable     : decrement by one per cycle while count is nonzero
//   done       : count has reached zero
// A load of N followed by enabled cycles raises done in the cycle that
// holds count 0, so a stretch of N+1 cycles ends on the done cycle.
// -----------------------------------------------------------------------------
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             slow_clock,
  input  logic             resetb,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Count down from the loaded value and park at zero.
  always_ff @(posedge slow_clock or posedge resetb) begin
    if (resetb) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/match_controller.sv
// -----------------------------------------------------------------------------
// match_controller
// Sequences repeated baccarat hands on the per-hand game state machine:
// parks the game in reset, releases it for one hand, classifies the result
// from the win lights, keeps win/tie tallies, holds the result display and
// ends the match on a target score or a hand limit.
// Ports:
//   slow_clock : clock, all state changes on the rising edge
//   resetb     : asynchronous active-high reset
//   bus        : match_controller_if.slave (start, lights, tallies, status)
// Parameters:
//   WIN_TARGET     : wins needed by either side to end the match
//   MAX_HANDS      : hand limit for one match
//   HOLD_CYCLES    : cycles the result is held (0 behaves as 1)
//   TIMEOUT_CYCLES : PLAY watchdog limit (used with MATCH_TIMEOUT_EN)
// Optional feature macro: MATCH_TIMEOUT_EN adds the PLAY watchdog and the
// sticky timeout_err output.
// Every output is a register; the lights only ever reach flops.
// -----------------------------------------------------------------------------
module match_controller
  import match_pkg::*;
#(
  parameter int WIN_TARGET     = 5,
  parameter int MAX_HANDS      = 15,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              slow_clock,
  input  logic              resetb,
  match_controller_if.slave bus
);

  // Both timers share one width, sized for the longer of the two loads.
  localparam int HOLD_LOAD = (HOLD_CYCLES > 1) ? HOLD_CYCLES - 1 : 0;
  localparam int WD_LOAD   = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int MAX_LOAD  = (HOLD_LOAD > WD_LOAD) ? HOLD_LOAD : WD_LOAD;
  localparam int TIMER_W   = $clog2(MAX_LOAD + 2);

  localparam logic [TALLY_W-1:0] TARGET_T = TALLY_W'(WIN_TARGET);
  localparam logic [TALLY_W-1:0] LIMIT_T  = TALLY_W'(MAX_HANDS);

  state_t               state;
  logic [TALLY_W-1:0]   player_q;
  logic [TALLY_W-1:0]   dealer_q;
  logic [TALLY_W-1:0]   tie_q;
  logic [TALLY_W-1:0]   hands_q;
  logic                 hand_resetb_q;
  logic                 match_over_q;
  winner_t              winner_q;
  logic                 start_q;

  logic                 start_rise;
  logic                 any_light;
  logic                 hold_load;
  logic                 hold_en;
  logic                 hold_done;

  // A start must rise while we sit in IDLE/DONE; a level left high from
  // before the match ended cannot restart it.
  assign start_rise = bus.start & ~start_q;
  assign any_light  = bus.player_win_light | bus.dealer_win_light;

  // The hold timer is armed on the PLAY edge that sees a result, so the
  // first HOLD cycle already counts toward the hold time.
  assign hold_load = (state == ST_PLAY) && any_light;
  assign hold_en   = (state == ST_HOLD);

  cycle_timer #(
    .WIDTH (TIMER_W)
  ) u_hold_timer (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .load       (hold_load),
    .load_value (TIMER_W'(HOLD_LOAD)),
    .enable     (hold_en),
    .done       (hold_done)
  );

`ifdef MATCH_TIMEOUT_EN
  logic wd_load;
  logic wd_en;
  logic wd_done;
  logic timeout_err_q;

  // The watchdog restarts on every hand release and runs only in PLAY.
  assign wd_load = (state == ST_HRST);
  assign wd_en   = (state == ST_PLAY);

  cycle_timer #(
    .WIDTH (TIMER_W)
  ) u_play_watchdog (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .load       (wd_load),
    .load_value (TIMER_W'(WD_LOAD)),
    .enable     (wd_en),
    .done       (wd_done)
  );

  assign bus.timeout_err = timeout_err_q;
`endif

  // Match sequencer: state, tallies and every registered output.
  always_ff @(posedge slow_clock or posedge resetb) begin
    if (resetb) begin
      state         <= ST_IDLE;
      player_q      <= '0;
      dealer_q      <= '0;
      tie_q         <= '0;
      hands_q       <= '0;
      hand_resetb_q <= 1'b0;
      match_over_q  <= 1'b0;
      winner_q      <= WIN_NONE;
      start_q       <= 1'b0;
`ifdef MATCH_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
    end else begin
      start_q <= bus.start;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_rise) begin
            player_q      <= '0;
            dealer_q      <= '0;
            tie_q         <= '0;
            hands_q       <= '0;
            winner_q      <= WIN_NONE;
            match_over_q  <= 1'b0;
            hand_resetb_q <= 1'b0;
`ifdef MATCH_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            state         <= ST_HRST;
          end
        end

        ST_HRST: begin
          hand_resetb_q <= 1'b1;
          state         <= ST_PLAY;
        end

        ST_PLAY: begin
          if (any_light) begin
            if (bus.player_win_light && bus.dealer_win_light) begin
              tie_q <= sat_inc(tie_q);
            end else if (bus.player_win_light) begin
              player_q <= sat_inc(player_q);
            end else begin
              dealer_q <= sat_inc(dealer_q);
            end
            hands_q <= sat_inc(hands_q);
            state   <= ST_HOLD;
          end
`ifdef MATCH_TIMEOUT_EN
          else if (wd_done) begin
            timeout_err_q <= 1'b1;
            winner_q      <= WIN_NONE;
            match_over_q  <= 1'b1;
            state         <= ST_DONE;
          end
`endif
        end

        ST_HOLD: begin
          if (hold_done) begin
            state <= ST_CHECK;
          end
        end

        // Target wins are tested before the hand limit, so a target reached
        // on the last allowed hand is still a win rather than a draw.
        ST_CHECK: begin
          if (player_q == TARGET_T) begin
            winner_q     <= WIN_PLAYER;
            match_over_q <= 1'b1;
            state        <= ST_DONE;
          end else if (dealer_q == TARGET_T) begin
            winner_q     <= WIN_DEALER;
            match_over_q <= 1'b1;
            state        <= ST_DONE;
          end else if (hands_q == LIMIT_T) begin
            if (player_q > dealer_q) begin
              winner_q <= WIN_PLAYER;
            end else if (dealer_q > player_q) begin
              winner_q <= WIN_DEALER;
            end else begin
              winner_q <= WIN_DRAW;
            end
            match_over_q <= 1'b1;
            state        <= ST_DONE;
          end else begin
            hand_resetb_q <= 1'b0;
            state         <= ST_HRST;
          end
        end

        default: begin
          hand_resetb_q <= 1'b0;
          match_over_q  <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.hand_resetb  = hand_resetb_q;
  assign bus.player_tally = player_q;
  assign bus.dealer_tally = dealer_q;
  assign bus.tie_tally    = tie_q;
  assign bus.hands_played = hands_q;
  assign bus.match_over   = match_over_q;
  assign bus.match_winner = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// -----------------------------------------------------------------------------
// tb_match_controller
// Drives two controllers: dut with default parameters and dut4 with a
// four-hand limit. The main process issues directed hands and pushes the
// hand-computed tallies into a queue; a monitor pops and compares whenever
// hands_played advances or match_over rises.
// Optional feature macro: MATCH_TIMEOUT_EN enables the watchdog test.
// -----------------------------------------------------------------------------
module tb_match_controller;

  typedef struct {
    int p;
    int d;
    int t;
    int h;
  } hand_exp_t;

  typedef struct {
    int winner;
    int terr;
  } done_exp_t;

  logic slow_clock = 1'b0;
  logic resetb;
  logic sel;
  logic start_s;
  logic p_light;
  logic d_light;

  int checks = 0;
  int errors = 0;

  hand_exp_t hand_q[$];
  done_exp_t done_q[$];

  int   mon_prev_h;
  logic mon_prev_mo;
  logic mon_prev_sel;

  match_controller_if bus  ();
  match_controller_if bus4 ();

  match_controller dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (bus)
  );

  match_controller #(
    .MAX_HANDS (4)
  ) dut4 (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (bus4)
  );

  always #5 slow_clock = ~slow_clock;

  // Stimulus goes only to the selected controller.
  assign bus.start             = sel ? 1'b0 : start_s;
  assign bus.player_win_light  = sel ? 1'b0 : p_light;
  assign bus.dealer_win_light  = sel ? 1'b0 : d_light;
  assign bus4.start            = sel ? start_s : 1'b0;
  assign bus4.player_win_light = sel ? p_light : 1'b0;
  assign bus4.dealer_win_light = sel ? d_light : 1'b0;

  logic       cur_hrb;
  logic [3:0] cur_p;
  logic [3:0] cur_d;
  logic [3:0] cur_t;
  logic [3:0] cur_h;
  logic       cur_mo;
  logic [1:0] cur_win;

  assign cur_hrb = sel ? bus4.hand_resetb  : bus.hand_resetb;
  assign cur_p   = sel ? bus4.player_tally : bus.player_tally;
  assign cur_d   = sel ? bus4.dealer_tally : bus.dealer_tally;
  assign cur_t   = sel ? bus4.tie_tally    : bus.tie_tally;
  assign cur_h   = sel ? bus4.hands_played : bus.hands_played;
  assign cur_mo  = sel ? bus4.match_over   : bus.match_over;
  assign cur_win = sel ? bus4.match_winner : bus.match_winner;

`ifdef MATCH_TIMEOUT_EN
  logic cur_terr;
  assign cur_terr = sel ? bus4.timeout_err : bus.timeout_err;
`endif

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic wait_hrb(input logic val, input string name);
    int n = 0;
    while (cur_hrb !== val && n < 50) begin
      @(negedge slow_clock);
      n++;
    end
    if (cur_hrb !== val) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: wait expired, hand_resetb=%b, expected %b", name, cur_hrb, val);
    end
  endtask

  task automatic wait_mo(input int budget, input string name);
    int n = 0;
    while (cur_mo !== 1'b1 && n < budget) begin
      @(negedge slow_clock);
      n++;
    end
    if (cur_mo !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: wait expired, match_over=%b, expected 1", name, cur_mo);
    end
  endtask

  task automatic start_match();
    @(negedge slow_clock);
    start_s = 1'b1;
    p_light = 1'b0;
    d_light = 1'b0;
    @(negedge slow_clock);
    start_s = 1'b0;
  endtask

  // One hand: wait for the release (unless already in PLAY), then raise the
  // result lights so they are sampled on PLAY cycle 'delay'.
  task automatic apply_stimulus(input logic p, input logic d, input int delay,
                                input bit in_play, input int ep, input int ed,
                                input int et, input int eh);
    hand_exp_t e;
    if (!in_play) begin
      wait_hrb(1'b0, "wait_hrst");
      p_light = 1'b0;
      d_light = 1'b0;
      wait_hrb(1'b1, "wait_play");
    end
    repeat (delay - 1) @(negedge slow_clock);
    e.p = ep;
    e.d = ed;
    e.t = et;
    e.h = eh;
    hand_q.push_back(e);
    p_light = p;
    d_light = d;
  endtask

  // Scoreboard monitor.
  initial begin
    hand_exp_t he;
    done_exp_t de;
    mon_prev_h   = 0;
    mon_prev_mo  = 1'b0;
    mon_prev_sel = 1'b0;
    forever begin
      @(negedge slow_clock);
      if (resetb !== 1'b1 && sel === mon_prev_sel) begin
        if (int'(cur_h) != mon_prev_h && cur_h != 4'd0) begin
          if (hand_q.size() == 0) begin
            check_output("unexpected_hand", int'(cur_h), 0);
          end else begin
            he = hand_q.pop_front();
            check_output("player_tally", int'(cur_p), he.p);
            check_output("dealer_tally", int'(cur_d), he.d);
            check_output("tie_tally", int'(cur_t), he.t);
            check_output("hands_played", int'(cur_h), he.h);
          end
        end
        if (cur_mo === 1'b1 && mon_prev_mo === 1'b0) begin
          if (done_q.size() == 0) begin
            check_output("unexpected_done", int'(cur_win), -1);
          end else begin
            de = done_q.pop_front();
            check_output("match_winner", int'(cur_win), de.winner);
`ifdef MATCH_TIMEOUT_EN
            check_output("timeout_err_done", int'(cur_terr), de.terr);
`endif
          end
        end
      end
      mon_prev_h   = int'(cur_h);
      mon_prev_mo  = cur_mo;
      mon_prev_sel = sel;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not complete, %0d errors so far", errors);
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    done_exp_t de;
    sel     = 1'b0;
    start_s = 1'b0;
    p_light = 1'b0;
    d_light = 1'b0;
    resetb  = 1'b1;

    repeat (2) @(negedge slow_clock);
    check_output("reset_hand_resetb", int'(cur_hrb), 0);
    check_output("reset_player", int'(cur_p), 0);
    check_output("reset_hands", int'(cur_h), 0);
    check_output("reset_match_over", int'(cur_mo), 0);
    check_output("reset_winner", int'(cur_win), 0);
    resetb = 1'b0;
    @(negedge slow_clock);
    check_output("idle_hand_resetb", int'(cur_hrb), 0);

    $display("[TB] sequencing and classification");
    start_match();
    apply_stimulus(1'b1, 1'b0, 3, 1'b0, 1, 0, 0, 1);
    @(negedge slow_clock);
    check_output("hold_entry_hrb", int'(cur_hrb), 1);
    repeat (3) @(negedge slow_clock);
    check_output("hold_last_hrb", int'(cur_hrb), 1);
    @(negedge slow_clock);
    check_output("check_state_hrb", int'(cur_hrb), 1);
    @(negedge slow_clock);
    check_output("hrst_low", int'(cur_hrb), 0);
    p_light = 1'b0;
    d_light = 1'b0;
    @(negedge slow_clock);
    check_output("hrst_one_cycle", int'(cur_hrb), 1);
    apply_stimulus(1'b0, 1'b1, 2, 1'b1, 1, 1, 0, 2);
    apply_stimulus(1'b1, 1'b1, 2, 1'b0, 1, 1, 1, 3);

    $display("[TB] reset mid-hand");
    wait_hrb(1'b0, "wait_hrst_rst");
    p_light = 1'b0;
    d_light = 1'b0;
    wait_hrb(1'b1, "wait_play_rst");
    @(negedge slow_clock);
    #2 resetb = 1'b1;
    #1;
    check_output("midrst_hand_resetb", int'(cur_hrb), 0);
    check_output("midrst_player", int'(cur_p), 0);
    check_output("midrst_dealer", int'(cur_d), 0);
    check_output("midrst_tie", int'(cur_t), 0);
    check_output("midrst_hands", int'(cur_h), 0);
    @(negedge slow_clock);
    resetb = 1'b0;
    repeat (2) @(negedge slow_clock);
    check_output("postrst_idle_hrb", int'(cur_hrb), 0);
    check_output("postrst_match_over", int'(cur_mo), 0);

    $display("[TB] target win");
    start_match();
    apply_stimulus(1'b1, 1'b0, 2, 1'b0, 1, 0, 0, 1);
    apply_stimulus(1'b0, 1'b1, 1, 1'b0, 1, 1, 0, 2);
    apply_stimulus(1'b1, 1'b0, 3, 1'b0, 2, 1, 0, 3);
    apply_stimulus(1'b0, 1'b1, 2, 1'b0, 2, 2, 0, 4);
    apply_stimulus(1'b1, 1'b0, 1, 1'b0, 3, 2, 0, 5);
    apply_stimulus(1'b1, 1'b0, 2, 1'b0, 4, 2, 0, 6);
    de.winner = 1;
    de.terr   = 0;
    done_q.push_back(de);
    apply_stimulus(1'b1, 1'b0, 2, 1'b0, 5, 2, 0, 7);
    start_s = 1'b1;
    wait_mo(30, "wait_target_done");
    repeat (5) @(negedge slow_clock);
    check_output("held_start_match_over", int'(cur_mo), 1);
    check_output("held_start_hands", int'(cur_h), 7);
    check_output("held_start_hrb", int'(cur_hrb), 1);
    check_output("held_start_winner", int'(cur_win), 1);
    start_s = 1'b0;
    @(negedge slow_clock);

    $display("[TB] hand limit draw");
    sel = 1'b1;
    repeat (2) @(negedge slow_clock);
    start_match();
    apply_stimulus(1'b1, 1'b0, 2, 1'b0, 1, 0, 0, 1);
    apply_stimulus(1'b0, 1'b1, 2, 1'b0, 1, 1, 0, 2);
    apply_stimulus(1'b1, 1'b1, 2, 1'b0, 1, 1, 1, 3);
    de.winner = 3;
    de.terr   = 0;
    done_q.push_back(de);
    apply_stimulus(1'b1, 1'b1, 2, 1'b0, 1, 1, 2, 4);
    wait_mo(30, "wait_limit_done");
    @(negedge slow_clock);
    start_match();
    check_output("restart_player", int'(cur_p), 0);
    check_output("restart_dealer", int'(cur_d), 0);
    check_output("restart_tie", int'(cur_t), 0);
    check_output("restart_hands", int'(cur_h), 0);
    check_output("restart_match_over", int'(cur_mo), 0);
    check_output("restart_winner", int'(cur_win), 0);
    check_output("restart_hrst", int'(cur_hrb), 0);
    @(negedge slow_clock);
    check_output("restart_play", int'(cur_hrb), 1);

`ifdef MATCH_TIMEOUT_EN
    $display("[TB] play watchdog");
    sel = 1'b0;
    repeat (2) @(negedge slow_clock);
    de.winner = 0;
    de.terr   = 1;
    done_q.push_back(de);
    start_match();
    check_output("terr_before_timeout", int'(cur_terr), 0);
    wait_mo(40, "wait_timeout_done");
    check_output("timeout_player", int'(cur_p), 0);
    check_output("timeout_hands", int'(cur_h), 0);
    check_output("timeout_err_set", int'(cur_terr), 1);
    start_match();
    check_output("timeout_err_cleared", int'(cur_terr), 0);
`endif

    repeat (2) @(negedge slow_clock);
    check_output("hand_queue_drained", hand_q.size(), 0);
    check_output("done_queue_drained", done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Sequences repeated baccarat hands on the existing per-hand game state machine.
- Parks the game in its reset state, releases it for one hand, and watches the win lights for the result.
- Classifies each result, keeps win/tie tallies, holds the result display for a programmable time, and ends the match on a target score or hand limit.
- Sits between the top level (start key) and the game state machine's reset input; tallies drive the HEX/LED display logic.

Parameters:
- WIN_TARGET, 5: wins needed by either side to end the match.
- MAX_HANDS, 15: hand limit; the match ends after this many hands regardless of tallies.
- HOLD_CYCLES, 4: slow_clock cycles the result is held before the next hand.
- TIMEOUT_CYCLES, 16: watchdog limit per hand (MATCH_TIMEOUT_EN only).

Ports:
- slow_clock  in  1  clock (all state changes on rising edge)
- resetb  in  1  asynchronous, active-high reset (asserted = 1)
- start  in  1  start/restart request, level, sampled in IDLE/DONE only
- player_win_light  in  1  from game state machine
- dealer_win_light  in  1  from game state machine
- hand_resetb  out  1  active-low synchronous reset to game state machine
- player_tally  out  4  player hands won
- dealer_tally  out  4  dealer hands won
- tie_tally  out  4  tied hands
- hands_played  out  4  hands completed this match
- match_over  out  1  high in DONE
- match_winner  out  2  00 none, 01 player, 10 dealer, 11 draw; valid when match_over
- timeout_err  out  1  MATCH_TIMEOUT_EN only; sticky until next start/reset

Behaviour:
- Reset (resetb=1, immediate): state IDLE; all tallies and hands_played 0; hand_resetb 0; match_over 0; match_winner 00; timeout_err 0. Reset mid-hand aborts without tally update.
- States: IDLE, HRST, PLAY, HOLD, CHECK, DONE.
- IDLE:
  - hand_resetb=0.
  - start=1: clear tallies/hands_played/winner, go to HRST.
- HRST:
  - hand_resetb=0 for exactly one cycle, then PLAY.
- PLAY:
  - hand_resetb=1.
  - Lights sampled each cycle. Any light high: update tallies on that edge and go to HOLD.
  - Classification: both lights → tie_tally+1; player only → player_tally+1; dealer only → dealer_tally+1. hands_played+1 in all three cases.
- HOLD:
  - hand_resetb=1, so the game stays in its winner state and the lights remain visible.
  - Counts HOLD_CYCLES cycles (entry cycle counts as 1), then CHECK.
  - HOLD_CYCLES=0 is treated as 1.
- CHECK (1 cycle):
  - player_tally==WIN_TARGET → DONE, winner 01.
  - Else dealer_tally==WIN_TARGET → DONE, winner 10.
  - Else hands_played==MAX_HANDS → DONE, winner set by tally comparison: 01 if player ahead, 10 if dealer ahead, 11 if equal.
  - Else → HRST.
- DONE:
  - match_over=1; hand_resetb=1, so the final hand's lights stay visible.
  - start=1 → clear as in IDLE, go to HRST.
- Priority: a player win is checked before a dealer win. A tally reaching WIN_TARGET on the same hand as hands_played reaching MAX_HANDS is a target win, not a draw.
- Tallies saturate at 15; an increment never wraps.
- start is ignored in HRST/PLAY/HOLD/CHECK.
- A start held high through DONE→HRST does not retrigger. It is re-sampled only in IDLE/DONE.
- All outputs are registered or decoded from state only. No combinational path from lights to outputs.

Optional Feature:
- Macro MATCH_TIMEOUT_EN.
- Defined:
  - PLAY counts cycles. If TIMEOUT_CYCLES cycles elapse with no light, go to DONE with timeout_err=1, match_winner 00, and no tally change.
  - timeout_err clears on start or reset.
- Undefined: no watchdog and no timeout_err port; PLAY waits indefinitely.

Decomposition:
- Shared package match_pkg:
  - state enum.
  - match_winner codes: WIN_NONE, WIN_PLAYER, WIN_DEALER, WIN_DRAW.
  - tally width constant TALLY_W=4.
- One sub-module, cycle_timer: loadable down-counter with a done flag. Instantiated for HOLD and, under MATCH_TIMEOUT_EN, for the PLAY watchdog.

Test Plan:
- Reset: assert resetb mid-PLAY → outputs immediately at reset values, state IDLE, hand_resetb=0.
- Sequencing: start pulse → hand_resetb low exactly 1 cycle, then high. Player light at PLAY cycle 3 → player_tally=1, hands_played=1, HOLD for 4 cycles, then HRST.
- Classification: drive results player, dealer, both → tallies 1/1/1, hands_played=3.
- Target win, defaults: five player wins interleaved with two dealer wins → DONE after hand 7, match_winner=01, match_over=1. Start held through DONE entry does not restart.
- Hand limit, MAX_HANDS=4, WIN_TARGET=5: results P, D, tie, tie → DONE, match_winner=11. Then start → all tallies 0, new hand begins.
- MATCH_TIMEOUT_EN with TIMEOUT_CYCLES=16: no lights for 16 cycles → DONE, timeout_err=1, winner 00, tallies unchanged. Then start clears timeout_err.
